// File: rtl/pwm_cmd_ctrl.sv
// pwm_cmd_ctrl: decodes I2C write frames (command byte + data byte) into double-buffered PWM settings
// Ports: i_clk clock; i_rst sync active-low reset; i_frame_start/i_byte_valid/i_rx_byte/i_frame_stop
// receiver byte stream; o_pwm_out registered PWM; o_cmd_err one-cycle reject pulse;
// o_busy frame open; o_duty_active duty currently driving the output.
module pwm_cmd_ctrl #(
  parameter logic [7:0] CMD_DUTY  = 8'hAB,
  parameter logic [7:0] CMD_PRESC = 8'hAC,
  parameter logic [7:0] CMD_CTRL  = 8'hAD,
  parameter logic [7:0] DUTY_RST  = 8'h00,
  parameter logic [7:0] PRESC_RST = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_start,
  input  logic       i_byte_valid,
  input  logic [7:0] i_rx_byte,
  input  logic       i_frame_stop,
  output logic       o_pwm_out,
  output logic       o_cmd_err,
  output logic       o_busy,
  output logic [7:0] o_duty_active
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, EXTRA} state_t;
  state_t r_state, w_state_b, w_state_nx;
  logic [7:0] r_cmd, r_dat, w_cmd_b, w_dat_b, w_cmd_nx, w_dat_nx;
  logic r_ovf, w_ovf_b, w_ovf_nx, w_known, w_commit, w_err, w_restart;
  logic [7:0] r_duty_pend, r_duty_act, r_presc_pend, r_presc_act, r_cnt, r_presc_cnt;
  logic r_en, r_err, r_pwm, w_tick, w_load;
  // The _b signals are the frame context after accepting this cycle's byte, so a stop in
  // the same cycle as the last byte commits with that byte included.
  always_comb begin
    w_state_b  = (i_byte_valid && r_state == CMD) ? DATA :
                 (i_byte_valid && r_state == DATA) ? EXTRA : r_state;
    w_cmd_b    = (i_byte_valid && r_state == CMD) ? i_rx_byte : r_cmd;
    w_dat_b    = (i_byte_valid && r_state == DATA) ? i_rx_byte : r_dat;
    w_ovf_b    = r_ovf || (i_byte_valid && r_state == EXTRA);
    w_known    = w_cmd_b inside {CMD_DUTY, CMD_PRESC, CMD_CTRL};
    w_commit   = i_frame_stop && w_state_b == EXTRA && !w_ovf_b && w_known;
    w_err      = i_frame_stop && w_state_b != IDLE && !w_commit;
    w_restart  = i_frame_start && !i_frame_stop;
    w_state_nx = i_frame_stop ? IDLE : w_restart ? CMD : w_state_b;
    w_cmd_nx   = w_restart ? 8'h00 : w_cmd_b;
    w_dat_nx   = w_restart ? 8'h00 : w_dat_b;
    w_ovf_nx   = !w_restart && w_ovf_b;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cmd   <= 8'h00;
      r_dat   <= 8'h00;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cmd   <= w_cmd_nx;
      r_dat   <= w_dat_nx;
      r_ovf   <= w_ovf_nx;
    end
  end
  // Active settings follow pending ones at each period wrap, or continuously while disabled.
  assign w_tick = r_presc_cnt == r_presc_act;
  assign w_load = !r_en || (w_tick && r_cnt == 8'hFF);
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_duty_pend  <= DUTY_RST;
      r_duty_act   <= DUTY_RST;
      r_presc_pend <= PRESC_RST;
      r_presc_act  <= PRESC_RST;
      r_en         <= 1'b1;
      r_cnt        <= 8'h00;
      r_presc_cnt  <= 8'h00;
      r_err        <= 1'b0;
      r_pwm        <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_commit && w_cmd_b == CMD_DUTY) r_duty_pend <= w_dat_b;
      if (w_commit && w_cmd_b == CMD_PRESC) r_presc_pend <= w_dat_b;
      if (w_commit && w_cmd_b == CMD_CTRL) r_en <= w_dat_b[0];
      if (w_load) begin
        r_duty_act  <= r_duty_pend;
        r_presc_act <= r_presc_pend;
      end
      r_presc_cnt <= (!r_en || w_tick) ? 8'h00 : r_presc_cnt + 8'h01;
      r_cnt       <= !r_en ? 8'h00 : w_tick ? r_cnt + 8'h01 : r_cnt;
      r_pwm       <= r_en && (r_cnt < r_duty_act);
    end
  end
  assign o_pwm_out     = r_pwm;
  assign o_cmd_err     = r_err;
  assign o_busy        = r_state != IDLE;
  assign o_duty_active = r_duty_act;
endmodule

// File: doc/pwm_cmd_ctrl.md
Name: pwm_cmd_ctrl

Overview:
- Downstream consumer of the I2C slave receiver's byte stream inside top.
- Decodes each write frame as one command byte followed by one data byte, e.g. 0xAB then 0x40 sets the PWM duty to 0x40.
- Holds the PWM configuration registers and drives pwm_out from an 8-bit prescaled counter.
- Duty and prescaler changes are double-buffered so a new setting takes effect only at a PWM period boundary.

Parameters:
- CMD_DUTY, 8'hAB, command code that writes the duty register.
- CMD_PRESC, 8'hAC, command code that writes the prescaler register.
- CMD_CTRL, 8'hAD, command code that writes the control register; bit0 = enable.
- DUTY_RST, 8'h00, duty value after reset.
- PRESC_RST, 8'h00, prescaler value after reset.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-low. The block is in reset on every clk rising edge where rst==0.
- frame_start  in  1  one-cycle pulse from the I2C slave: START/repeated-START followed by an address match with a write bit.
- byte_valid  in  1  one-cycle pulse: rx_byte holds a received data byte (the address byte is excluded).
- rx_byte  in  8  received byte; valid only when byte_valid==1.
- frame_stop  in  1  one-cycle pulse: STOP detected on the bus.
- pwm_out  out  1  PWM output, registered.
- cmd_err  out  1  one-cycle pulse when a frame is rejected.
- busy  out  1  high while a frame is open (between frame_start and frame_stop).
- duty_active  out  8  duty value currently in use, for status/debug.

Behaviour:
- Reset (rst==0 at a clk edge):
  - pwm_out=0, cmd_err=0, busy=0.
  - duty_active=duty_pend=DUTY_RST; presc_active=presc_pend=PRESC_RST; en=1.
  - cnt=0, presc_cnt=0, FSM=IDLE.
  - Any partially received frame is discarded with no commit and no cmd_err.
- FSM states: IDLE, CMD, DATA, EXTRA.
  - IDLE --frame_start--> CMD.
  - CMD --byte_valid--> DATA, latching cmd=rx_byte.
  - DATA --byte_valid--> EXTRA, latching dat=rx_byte.
  - EXTRA --byte_valid--> EXTRA, setting the overflow flag.
  - frame_start in any state returns to CMD, clears the latched bytes and the flag, with no commit and no cmd_err (repeated START).
  - frame_stop in any state returns to IDLE.
  - busy=1 in CMD, DATA and EXTRA.
- Commit on frame_stop:
  - If the state is EXTRA, overflow is clear and cmd is known:
    - CMD_DUTY: duty_pend=dat.
    - CMD_PRESC: presc_pend=dat.
    - CMD_CTRL: en=dat[0], effective immediately.
  - Rejected frames assert cmd_err for exactly 1 cycle and leave all registers unchanged:
    - stop in CMD (no bytes received);
    - stop in DATA (command byte only);
    - overflow set (3 or more bytes);
    - unknown command code.
  - frame_stop in IDLE is ignored: no cmd_err.
  - cmd_err is asserted on the cycle after frame_stop is sampled.
- Simultaneous pulses:
  - byte_valid and frame_stop in the same cycle: the byte is accepted first, then the stop/commit is evaluated.
  - frame_start and frame_stop in the same cycle: stop is processed, start is ignored.
- Prescaler and counter:
  - tick=1 when presc_cnt==presc_active; presc_cnt then resets to 0, otherwise it increments.
  - On tick, cnt increments modulo 256 (wraps 255→0).
  - Period = 256*(presc_active+1) clk cycles.
- Double buffering:
  - On the tick where cnt wraps 255→0: duty_active<=duty_pend, presc_active<=presc_pend.
  - A commit landing on the same cycle as the wrap is applied at the following wrap.
- Output:
  - pwm_out <= en && (cnt < duty_active); registered, so it lags cnt by 1 cycle.
  - duty 0 gives constant 0; duty 255 gives high for 255 of 256 counts.
- en=0:
  - cnt and presc_cnt are held at 0 and pwm_out=0 from the next cycle.
  - Pending values load immediately while disabled.
  - Re-enabling restarts the period at cnt=0.

Test Plan:
- Reset → pwm_out=0, busy=0, duty_active=0x00. Assert rst=0 mid-frame (after the 0xAB byte), release, then frame_stop → no commit, no cmd_err.
- frame_start, bytes 0xAB, 0x40, frame_stop with presc=0 → duty_active=0x40 at the next wrap; pwm_out high for 64 of every 256 cycles; cmd_err stays 0.
- frame_start, 0xAC, 0x03, stop, then 0xAB, 0x80, stop → after the wraps, period=1024 clk and high time=512 clk.
- frame_start, 0xAB, stop (one byte) → cmd_err 1-cycle pulse, duty unchanged. Bytes 0xAB, 0x10, 0x20 (three bytes) → cmd_err, duty unchanged. Command 0x55 → cmd_err.
- Write 0xAD, 0x00 → pwm_out=0 and cnt=0 held; write duty 0xFF while disabled → duty_active=0xFF immediately. Write 0xAD, 0x01 → pwm_out low exactly 1 count per period.
- Bytes 0xAB, 0x20 then frame_start (repeated START), 0xAB, 0x30, stop → duty_active=0x30, no cmd_err. Separately, byte_valid and frame_stop in the same cycle on the second byte → commit succeeds.
